// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven instruction fetch into a small valid/ready FIFO with flush support
module fetch_queue #(
    parameter int          DEPTH   = 2,
    parameter int          IMEM_AW = 10,
    parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    input  logic               pc_valid,
    output logic               pc_accept,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic               out_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW:0]   count_q, count_d, occ;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          inflight_q, inflight_err_q, fault, pop, push;
    logic [31:0]   inflight_pc_q, off;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [DEPTH-1:0] err_mem_q;

    assign off       = pc_in - PC_BASE;
    assign fault     = (|pc_in[1:0]) | (pc_in < PC_BASE) | (|(off >> (IMEM_AW + 2)));
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & ~flush & ~reset;
    // Slots already promised (stored + in flight) after this cycle's pop must leave room
    assign occ       = count_q + (PW+1)'(inflight_q) - (PW+1)'(pop);
    assign pc_accept = pc_valid & ~flush & ~reset & (occ < FULL);
    assign imem_en   = pc_accept;
    assign imem_addr = off[IMEM_AW+1:2];
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_err   = out_valid & err_mem_q[rd_ptr_q];

    // Next FIFO bookkeeping; flush empties the queue by snapping rd_ptr to wr_ptr
    always_comb begin
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end
    end

    // Control state; the in-flight tag lives exactly one cycle after each accept
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            inflight_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= pc_accept;
            if (pc_accept) begin
                inflight_pc_q  <= pc_in;
                inflight_err_q <= fault;
            end
        end
    end

    // Entry storage; faulting requests store a zero instruction instead of ROM data
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
            instr_mem_q[wr_ptr_q] <= inflight_err_q ? '0 : imem_rdata;
            err_mem_q[wr_ptr_q]   <= inflight_err_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch latency, back-pressure, flush, faults and reset
module tb_fetch_queue;
    logic        clk, reset, pc_valid, pc_accept, imem_en, flush;
    logic        out_valid, out_ready, out_err;
    logic [31:0] pc_in, imem_rdata, out_pc, out_instr;
    logic [9:0]  imem_addr;
    int          n_tests = 0;
    int          n_fail = 0;

    fetch_queue dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_accept(pc_accept), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    // Synchronous ROM model: data one cycle after the enable
    always @(posedge clk) if (imem_en) imem_rdata <= rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic err);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, err ? 32'h0 : rom(10'((pc - 32'h3000) >> 2)));
        chk({tag, ".err"}, 32'(out_err), 32'(err));
    endtask

    logic [31:0] pcs [4];
    logic        errs [4];

    initial begin
        reset = 1'b1; pc_valid = 1'b1; pc_in = 32'h3000; flush = 1'b0; out_ready = 1'b0;
        // 1: reset holds everything idle, release keeps outputs zero
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.valid", 32'(out_valid), 32'd0);
            chk("rst.accept", 32'(pc_accept), 32'd0);
            next_cyc();
        end
        reset = 1'b0; pc_valid = 1'b0;
        @(negedge clk);
        chk("rel.valid", 32'(out_valid), 32'd0);
        chk("rel.accept", 32'(pc_accept), 32'd0);
        chk("rel.pc", out_pc, 32'h0);
        chk("rel.instr", out_instr, 32'h0);
        chk("rel.err", 32'(out_err), 32'd0);
        next_cyc();
        // 2: streaming at one instruction per cycle, two-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_valid = i < 3;
            pc_in = 32'h3000 + 32'(4 * i);
            @(negedge clk);
            if (i < 3) chk("str.accept", 32'(pc_accept), 32'd1);
            if (i == 0) chk("str.addr", 32'(imem_addr), 32'd0);
            if (i < 2) chk("str.lat", 32'(out_valid), 32'd0);
            else if (i < 5) chk_out("str", 32'h3000 + 32'(4 * (i - 2)), 1'b0);
            else chk("str.empty", 32'(out_valid), 32'd0);
            next_cyc();
        end
        // 3: back-pressure fills the queue, head holds, release resumes in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_valid = 1'b1;
            pc_in = (i < 2) ? 32'h3000 + 32'(4 * i) : 32'h3008;
            @(negedge clk);
            chk("bp.accept", 32'(pc_accept), (i < 2) ? 32'd1 : 32'd0);
            if (i >= 2) chk_out("bp.head", 32'h3000, 1'b0);
            next_cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_valid = i < 3;
            pc_in = 32'h3008 + 32'(4 * i);
            @(negedge clk);
            if (i < 3) chk("rel.accept", 32'(pc_accept), 32'd1);
            if (i < 5) chk_out("rel.ord", 32'h3000 + 32'(4 * i), 1'b0);
            else chk("rel.empty", 32'(out_valid), 32'd0);
            next_cyc();
        end
        // 4: flush with one queued and one in flight discards both
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pc_valid = 1'b1;
            pc_in = 32'h3000 + 32'(4 * i);
            @(negedge clk);
            chk("fl.fill", 32'(pc_accept), 32'd1);
            next_cyc();
        end
        flush = 1'b1; pc_in = 32'h3008;
        @(negedge clk);
        chk("fl.noacc", 32'(pc_accept), 32'd0);
        next_cyc();
        flush = 1'b0; pc_in = 32'h3100;
        @(negedge clk);
        chk("fl.empty", 32'(out_valid), 32'd0);
        chk("fl.acc", 32'(pc_accept), 32'd1);
        next_cyc();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("fl.nostale", 32'(out_valid), 32'd0);
        next_cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("fl.new", 32'h3100, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("fl.drain", 32'(out_valid), 32'd0);
        next_cyc();
        // 5: misaligned, below base and past ROM end fault; last ROM word does not
        pcs[0] = 32'h3002; pcs[1] = 32'h2FFC; pcs[2] = 32'h4000; pcs[3] = 32'h3FFC;
        errs[0] = 1'b1; errs[1] = 1'b1; errs[2] = 1'b1; errs[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc_valid = i < 4;
            pc_in = pcs[i % 4];
            @(negedge clk);
            if (i < 4) chk("flt.accept", 32'(pc_accept), 32'd1);
            if (i == 3) chk("flt.addr", 32'(imem_addr), 32'h3FF);
            if (i >= 2) chk_out("flt", pcs[i - 2], errs[i - 2]);
            next_cyc();
        end
        // 6: reset mid-operation drops queue and the late ROM response
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pc_valid = 1'b1;
            pc_in = 32'h3000 + 32'(4 * i);
            next_cyc();
        end
        reset = 1'b1; pc_in = 32'h3008;
        @(negedge clk);
        chk("mr.accept", 32'(pc_accept), 32'd0);
        next_cyc();
        reset = 1'b0; pc_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mr.valid", 32'(out_valid), 32'd0);
            chk("mr.pc", out_pc, 32'h0);
            next_cyc();
        end
        pc_valid = 1'b1; pc_in = 32'h3200; out_ready = 1'b1;
        @(negedge clk);
        chk("mr.acc", 32'(pc_accept), 32'd1);
        next_cyc();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("mr.lat", 32'(out_valid), 32'd0);
        next_cyc();
        @(negedge clk);
        chk_out("mr.new", 32'h3200, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("mr.drain", 32'(out_valid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
